load_store_unit: RTL

MEM-stage initiator that drives the doubleword-wide data memory on behalf of the pipeline. Accepts one load or store per handshake in byte, half, word or double size. Stores narrower than 64 bits are done as read-modify-write, because memory writes always cover 8 bytes. Loads are returned sign- or zero-extended; misaligned, out-of-range and timed-out accesses are reported as errors.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 41 ++++
 rtl/load_store_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the size-to-byte-count helper.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: extracts and extends load data from a
// doubleword, and merges narrow store data into a read doubleword.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [63:0] rdata,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] merged
);

    logic [63:0] raw;
    logic [63:0] wdata_shifted;
    logic [8:0]  lane_ones;
    logic [7:0]  byte_mask;
    logic [63:0] bit_mask;

    always_comb begin
        raw = rdata >> {off, 3'b000};
        case (size)
            SZ_B:    load_data = is_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            SZ_H:    load_data = is_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            SZ_W:    load_data = is_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: load_data = raw;
        endcase

        // 9-bit intermediate so a full doubleword (8 lanes) does not overflow
        lane_ones = (9'd1 << size_bytes(size)) - 9'd1;
        byte_mask = lane_ones[7:0] << off;
        bit_mask  = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[8*i +: 8] = {8{byte_mask[i]}};
        end
        wdata_shifted = wdata << {off, 3'b000};
        merged        = (rdata & ~bit_mask) | (wdata_shifted & bit_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a doubleword data memory, with
// read-modify-write for narrow stores. Optional counters: LSU_PERF_COUNTERS_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack
`ifdef LSU_PERF_COUNTERS_EN
    ,
    output logic [31:0] load_count,
    output logic [31:0] store_count,
    output logic [31:0] error_count
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state_q, state_d;
    logic [2:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              store_q, store_d;
    logic              unsigned_q, unsigned_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_error_q, resp_error_d;
    logic [63:0]       resp_rdata_q, resp_rdata_d;
    logic [63:0]       mem_addr_q, mem_addr_d;
    logic [63:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic [63:0]       load_data;
    logic [63:0]       merged_data;
    logic [3:0]        req_nbytes;
    logic              misaligned;
    logic              out_of_range;

    lsu_align u_align (
        .off        (off_q),
        .size       (size_q),
        .is_unsigned(unsigned_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merged     (merged_data)
    );

    // 65-bit sum so addresses near the top of the 64-bit space cannot wrap into range
    always_comb begin
        req_nbytes   = size_bytes(req_size);
        misaligned   = (req_addr[2:0] & 3'(req_nbytes - 4'd1)) != 3'd0;
        out_of_range = ({1'b0, req_addr} + 65'(req_nbytes)) > 65'(MEM_BYTES);
    end

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        size_d       = size_q;
        store_d      = store_q;
        unsigned_d   = unsigned_q;
        wdata_d      = wdata_q;
        tmo_cnt_d    = tmo_cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_rdata_d = '0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_d       = req_addr[2:0];
                    size_d      = req_size;
                    store_d     = req_store;
                    unsigned_d  = req_unsigned;
                    wdata_d     = req_wdata;
                    mem_addr_d  = {req_addr[63:3], 3'b000};
                    tmo_cnt_d   = '0;
                    req_ready_d = 1'b0;
                    if (misaligned || out_of_range) begin
                        state_d      = ERR;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (req_store && req_size == SZ_D) begin
                        state_d     = WR;
                        mem_write_d = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d    = RD;
                        mem_read_d = 1'b1;
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    mem_read_d = 1'b0;
                    if (store_q) begin
                        state_d     = WR;
                        mem_write_d = 1'b1;
                        mem_wdata_d = merged_data;
                        tmo_cnt_d   = '0;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_data;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    mem_read_d   = 1'b0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            WR: begin
                if (mem_ack) begin
                    mem_write_d  = 1'b0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    mem_write_d  = 1'b0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            RESP, ERR: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            off_q        <= '0;
            size_q       <= SZ_B;
            store_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            wdata_q      <= '0;
            tmo_cnt_q    <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            size_q       <= size_d;
            store_q      <= store_d;
            unsigned_q   <= unsigned_d;
            wdata_q      <= wdata_d;
            tmo_cnt_q    <= tmo_cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;

`ifdef LSU_PERF_COUNTERS_EN
    logic [31:0] load_cnt_q, load_cnt_d;
    logic [31:0] store_cnt_q, store_cnt_d;
    logic [31:0] error_cnt_q, error_cnt_d;

    // store_q is still the completing request's type while resp_valid is high
    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        error_cnt_d = error_cnt_q;
        if (resp_valid_q) begin
            if (resp_error_q) begin
                if (error_cnt_q != 32'hFFFF_FFFF) error_cnt_d = error_cnt_q + 32'd1;
            end else if (store_q) begin
                if (store_cnt_q != 32'hFFFF_FFFF) store_cnt_d = store_cnt_q + 32'd1;
            end else begin
                if (load_cnt_q != 32'hFFFF_FFFF) load_cnt_d = load_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            error_cnt_q <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            error_cnt_q <= error_cnt_d;
        end
    end

    assign load_count  = load_cnt_q;
    assign store_count = store_cnt_q;
    assign error_count = error_cnt_q;
`endif

endmodule
